// File: rtl/clr_st_sched.sv
`default_nettype none
// ============================================================================
// clr_st_sched : scans N_CH signed channels, classifies each into a 2-bit code
//   and shares one registered color lookup. Optional hysteresis: CLR_SCHED_HYS_EN
// Revision 1.0
// ============================================================================
module clr_st_sched #(
  parameter int            N_CH = 4,
  parameter int            W    = 16,
  parameter logic [W-1:0]  TH   = 16'd8192,
  parameter logic [W-1:0]  HYS  = 16'd256,
  localparam int           CW   = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_CH*W-1:0]    sig_in,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           clrst,
  output logic                 clrst_vld,
  output logic [CW-1:0]        ch_idx,
  input  logic [23:0]          color_in,
  output logic [N_CH*24-1:0]   color_out
);

`ifdef CLR_SCHED_HYS_EN
  localparam bit HYS_ON = 1'b1;
`else
  localparam bit HYS_ON = 1'b0;
`endif

  // Comparisons run at W+2 bits so -2^(W-1) and TH+HYS never wrap.
  localparam logic signed [W+1:0] TH_X  = $signed({2'b00, TH});
  // A zero margin makes the step rules identical to the raw classification.
  localparam logic signed [W+1:0] HYS_X = HYS_ON ? $signed({2'b00, HYS}) : '0;
  localparam logic [CW-1:0]       LAST  = CW'(N_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_CLASS  = 3'd2,
    S_WAIT   = 3'd3,
    S_STORE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t               state;
  logic signed [W-1:0]  s_reg;
  logic [1:0]           st [N_CH];

  logic signed [W+1:0]  x_ext;
  logic [1:0]           raw;
  logic [1:0]           prev;
  logic [1:0]           nxt;

  // Lower boundary of the step between code lo and lo+1.
  function automatic logic signed [W+1:0] bnd(input logic [1:0] lo);
    case (lo)
      2'd0:    bnd = -TH_X;
      2'd1:    bnd = '0;
      default: bnd = TH_X;
    endcase
  endfunction

  always_comb begin
    x_ext = {{2{s_reg[W-1]}}, s_reg};
    prev  = st[ch_idx];

    if (x_ext < -TH_X)     raw = 2'd0;
    else if (x_ext[W+1])   raw = 2'd1;
    else if (x_ext < TH_X) raw = 2'd2;
    else                   raw = 2'd3;

    nxt = raw;
    if ({1'b0, raw} == {1'b0, prev} + 3'd1) begin
      if (x_ext < bnd(prev) + HYS_X) nxt = prev;
    end else if ({1'b0, prev} == {1'b0, raw} + 3'd1) begin
      if (x_ext >= bnd(raw) - HYS_X) nxt = prev;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      clrst     <= 2'b00;
      clrst_vld <= 1'b0;
      ch_idx    <= '0;
      s_reg     <= '0;
      color_out <= '0;
      for (int k = 0; k < N_CH; k++) st[k] <= 2'b10;
    end else begin
      done      <= 1'b0;
      clrst_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_SAMPLE;
            busy   <= 1'b1;
            ch_idx <= '0;
          end
        end
        S_SAMPLE: begin
          s_reg <= sig_in[32'(ch_idx) * W +: W];
          state <= S_CLASS;
        end
        S_CLASS: begin
          st[ch_idx] <= nxt;
          clrst      <= nxt;
          clrst_vld  <= 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          state <= S_STORE;
        end
        S_STORE: begin
          color_out[32'(ch_idx) * 24 +: 24] <= color_in;
          if (ch_idx == LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            ch_idx <= ch_idx + CW'(1);
            state  <= S_SAMPLE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
